inst_fetch_unit: RTL and testbench

//  Fetch stage of each multicore core; sits directly upstream of decode.

---
 rtl/inst_fetch_unit_pkg.sv | 13 +
 rtl/fetch_line_buffer.sv | 22 ++
 rtl/inst_fetch_unit.sv | 69 ++++++
 tb/tb_inst_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared fetch-stage types and geometry constants
package inst_fetch_unit_pkg;
  localparam int INST_SIZE = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_SIZE = WORDS_PER_LINE * INST_SIZE / 8;
  localparam int LINE_BITS = LINE_SIZE * 8;
  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFFSET = $clog2(INST_SIZE / 8);
  localparam int TAG_BITS = 32 - OFFSET - WORD_BITS;
  localparam logic [6:0] NOOP_CODE = 7'h13;
  localparam logic [INST_SIZE-1:0] NOOP_INST = {{(INST_SIZE-7){1'b0}}, NOOP_CODE};
  typedef enum logic [1:0] {F_REQ, F_WAIT, F_SERVE} t_fetch_state;
endpackage

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: one-line instruction buffer with tag compare and word select
module fetch_line_buffer import inst_fetch_unit_pkg::*; (
  input  logic                 clk,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] line_in,
  input  logic [TAG_BITS-1:0]  tag_in,
  input  logic [WORD_BITS-1:0] idx,
  input  logic [TAG_BITS-1:0]  cmp_tag,
  output logic [INST_SIZE-1:0] word,
  output logic                 hit
);
  logic [LINE_BITS-1:0] line_buf;
  logic [TAG_BITS-1:0]  line_tag;
  always_ff @(posedge clk) begin
    if (load) begin
      line_buf <= line_in;
      line_tag <= tag_in;
    end
  end
  assign word = line_buf[INST_SIZE*int'(idx) +: INST_SIZE];
  assign hit = cmp_tag == line_tag;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: line-based instruction fetch with redirect handling and decode handshake
module inst_fetch_unit import inst_fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [INST_SIZE-1:0] inst,
  output logic [31:0]          inst_pc,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_req_addr,
  input  logic                 mem_resp_valid,
  input  logic [LINE_BITS-1:0] mem_resp_data
);
  t_fetch_state         state, state_n;
  logic [31:0]          pc, pc_n, rpc, line_pc;
  logic                 discard, discard_n, load, hit;
  logic [WORD_BITS-1:0] idx;
  logic [INST_SIZE-1:0] word;
  assign rpc = redirect_pc & ~32'(INST_SIZE/8 - 1);
  assign idx = pc[OFFSET+WORD_BITS-1:OFFSET];
  fetch_line_buffer u_buf (
    .clk,
    .load,
    .line_in (mem_resp_data),
    .tag_in  (pc[31:OFFSET+WORD_BITS]),
    .idx,
    .cmp_tag (rpc[31:OFFSET+WORD_BITS]),
    .word,
    .hit
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= F_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
    end
  end
  always_comb begin
    state_n   = state;
    pc_n      = redirect_valid ? rpc : pc;
    discard_n = discard;
    load      = 1'b0;
    if (state == F_REQ) begin
      state_n = mem_req_ready ? F_WAIT : F_REQ;
    end else if (state == F_WAIT) begin
      load      = mem_resp_valid && !discard && !redirect_valid;
      state_n   = load ? F_SERVE : mem_resp_valid ? F_REQ : F_WAIT;
      discard_n = redirect_valid ? !mem_resp_valid : mem_resp_valid ? 1'b0 : discard;
    end else begin
      pc_n    = redirect_valid ? rpc : inst_ready ? pc + 32'd4 : pc;
      state_n = redirect_valid ? (hit ? F_SERVE : F_REQ) : (inst_ready && &idx) ? F_REQ : F_SERVE;
    end
  end
  assign line_pc       = redirect_valid ? rpc : pc;
  assign inst_valid    = !rst && state == F_SERVE;
  assign inst          = inst_valid ? word : NOOP_INST;
  assign inst_pc       = rst ? RESET_PC : pc;
  assign mem_req_valid = !rst && state == F_REQ;
  assign mem_req_addr  = {line_pc[31:OFFSET+WORD_BITS], {(OFFSET+WORD_BITS){1'b0}}};
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed stimulus with a stream-level fetch model and memory responder
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;
  logic                 clk, rst, redirect_valid, inst_valid, inst_ready;
  logic                 mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0]          redirect_pc, inst_pc, mem_req_addr;
  logic [INST_SIZE-1:0] inst;
  logic [LINE_BITS-1:0] mem_resp_data;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} d_t;
  d_t          delivered[$];
  int          checks = 0, errors = 0, req_count = 0, cnt = 0;
  logic        outstanding = 1'b0;
  logic [31:0] pend, exp_pc, rp, a;
  int          n, rc;
  inst_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk, .rst, .redirect_valid, .redirect_pc, .inst_valid, .inst_ready, .inst, .inst_pc,
    .mem_req_valid, .mem_req_ready, .mem_req_addr, .mem_resp_valid, .mem_resp_data
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] memword(input logic [31:0] addr);
    return 32'h100 + (addr >> 2);
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    mem_resp_valid = 1'b0;
    if (outstanding) begin
      cnt--;
      if (cnt == 0) begin
        mem_resp_valid = 1'b1;
        for (int i = 0; i < WORDS_PER_LINE; i++) mem_resp_data[32*i +: 32] = memword(pend + 32'(4*i));
        outstanding = 1'b0;
      end
    end
    #2;
    rp = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      chk("rst_inst_valid", {31'b0, inst_valid}, 0);
      chk("rst_inst", inst, 32'h13);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
      exp_pc = 32'h0;
      outstanding = 1'b0;
    end else begin
      if (inst_valid) begin
        chk("stream_pc", inst_pc, exp_pc);
        chk("stream_inst", inst, memword(exp_pc));
        if (inst_ready) delivered.push_back('{inst_pc, inst});
      end else begin
        chk("idle_noop", inst, 32'h13);
      end
      chk("req_while_serving", {31'b0, mem_req_valid && inst_valid}, 0);
      if (mem_req_valid && mem_req_ready) begin
        chk("single_outstanding", {31'b0, outstanding}, 0);
        chk("req_addr", mem_req_addr, (redirect_valid ? rp : exp_pc) & 32'hFFFF_FFE0);
        outstanding = 1'b1;
        cnt = 2;
        pend = mem_req_addr;
        req_count++;
      end
      exp_pc = redirect_valid ? rp : (inst_valid && inst_ready) ? exp_pc + 32'd4 : exp_pc;
    end
  end
  task automatic wait_req(output logic [31:0] addr);
    addr = 32'hDEAD_BEEF;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (mem_req_valid && mem_req_ready) begin
        addr = mem_req_addr;
        return;
      end
      @(negedge clk);
    end
    chk("wait_req_timeout", 32'd1, 32'd0);
  endtask
  task automatic wait_pc(input logic [31:0] p);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (inst_valid && inst_pc == p) return;
      @(negedge clk);
    end
    chk("wait_pc_timeout", p, 32'hFFFF_FFFF);
  endtask
  task automatic wait_deliv(input int cnt_needed);
    for (int k = 0; k < 100; k++) begin
      #3;
      if (delivered.size() >= cnt_needed) return;
      @(negedge clk);
    end
    chk("wait_deliv_timeout", 32'(delivered.size()), 32'(cnt_needed));
  endtask
  task automatic chk_deliv(input int i, input logic [31:0] p, input logic [31:0] w);
    if (i < delivered.size()) begin
      chk("deliv_pc", delivered[i].pc, p);
      chk("deliv_inst", delivered[i].ins, w);
    end else begin
      chk("deliv_missing", 32'(i), 32'(delivered.size()));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1; mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_req(a);
    chk("t1_first_req", a, 32'h0);
    @(negedge clk);
    wait_deliv(8);
    for (int i = 0; i < 8; i++) chk_deliv(i, 32'(4*i), 32'h100 + 32'(i));
    @(negedge clk);
    wait_req(a);
    chk("t1_next_req", a, 32'h20);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc(32'hC);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t2_hold_valid", {31'b0, inst_valid}, 1);
      chk("t2_hold_inst", inst, 32'h103);
      chk("t2_hold_pc", inst_pc, 32'hC);
    end
    @(negedge clk);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h14; rc = req_count;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t3_valid", {31'b0, inst_valid}, 1);
    chk("t3_inst", inst, 32'h105);
    chk("t3_pc", inst_pc, 32'h14);
    chk("t3_no_req", 32'(req_count), 32'(rc));
    @(negedge clk);
    wait_pc(32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_req(a);
    chk("t4_req_line0", a, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h48; n = delivered.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_req(a);
    chk("t4_req", a, 32'h40);
    @(negedge clk);
    wait_deliv(n + 1);
    chk_deliv(n, 32'h48, 32'h112);
    @(negedge clk);
    mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t5_stalled_valid", {31'b0, mem_req_valid}, 1);
    chk("t5_stalled_addr", mem_req_addr, 32'h20);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h84; mem_req_ready = 1'b1; n = delivered.size();
    #1;
    chk("t5_req_addr", mem_req_addr, 32'h80);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_deliv(n + 1);
    chk_deliv(n, 32'h84, 32'h121);
    @(negedge clk);
    wait_req(a);
    chk("t6_req", a, 32'hA0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, inst_valid}, 0);
    chk("t6_rst_inst", inst, 32'h13);
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1F; n = delivered.size();
    #1;
    chk("t6_req_valid", {31'b0, mem_req_valid}, 1);
    chk("t6_req_addr", mem_req_addr, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_deliv(n + 1);
    chk_deliv(n, 32'h1C, 32'h107);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; n = delivered.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_deliv(n + 3);
    chk_deliv(n, 32'hFFFF_FFF8, 32'h4000_00FE);
    chk_deliv(n + 1, 32'hFFFF_FFFC, 32'h4000_00FF);
    chk_deliv(n + 2, 32'h0, 32'h100);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
